// File: rtl/readout_stream_arbiter.sv
// readout_stream_arbiter
//  Scans up to N_SOURCES snapshot readout memories over one shared address bus and
//  serialises their entries onto a single valid/ready stream tagged with source and
//  index. Triggers are rising edges of readoutValid while readoutActive is high;
//  pending triggers are serviced round robin, one full scan per trigger.
//
//  Optional feature: define READOUT_STREAM_SKIP_ABSENT_EN to suppress beats for
//  entries whose present flag is 0. Default build emits every entry, with absent
//  entries carrying zero data.
//
// Ports
//  sysClk, sysReset   clock, asynchronous active-high reset
//  readoutActive      per-source snapshot active
//  readoutValid       per-source snapshot valid (rising edge = trigger)
//  readoutSel         source currently addressed
//  readoutAddress     shared read address
//  readoutData        concatenated per-source read data, source 0 in the LSBs
//  readoutPresent     per-source present flag for the addressed entry
//  streamSource/Index/Data/Valid, streamReady   output stream
//  scanDone           one-cycle pulse at the end of each scan
//  busy               high whenever a scan is in progress
//  overrunCount       saturating count of dropped/merged triggers and aborts
module readout_stream_arbiter #(
    parameter int unsigned N_SOURCES   = 2,
    parameter int unsigned SRC_WIDTH   = 1,
    parameter int unsigned INDEX_WIDTH = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic                            sysClk,
    input  logic                            sysReset,
    input  logic [N_SOURCES-1:0]            readoutActive,
    input  logic [N_SOURCES-1:0]            readoutValid,
    output logic [SRC_WIDTH-1:0]            readoutSel,
    output logic [INDEX_WIDTH-1:0]          readoutAddress,
    input  logic [N_SOURCES*DATA_WIDTH-1:0] readoutData,
    input  logic [N_SOURCES-1:0]            readoutPresent,
    output logic [SRC_WIDTH-1:0]            streamSource,
    output logic [INDEX_WIDTH-1:0]          streamIndex,
    output logic [DATA_WIDTH-1:0]           streamData,
    output logic                            streamValid,
    input  logic                            streamReady,
    output logic                            scanDone,
    output logic                            busy,
    output logic [15:0]                     overrunCount
);

    localparam int unsigned LAT_WIDTH = 2;
    localparam int unsigned INC_WIDTH = 5;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EMIT,
        ST_DONE
    } stateT;

    stateT                  state;
    logic [N_SOURCES-1:0]   validQ;
    logic [N_SOURCES-1:0]   activeQ;
    logic [N_SOURCES-1:0]   pending;
    logic [SRC_WIDTH-1:0]   rrPtr;
    logic [LAT_WIDTH-1:0]   latCnt;
    logic                   abortPending;

    logic [N_SOURCES-1:0]   validRise;
    logic [N_SOURCES-1:0]   activeFall;
    logic [N_SOURCES-1:0]   setMask;
    logic [N_SOURCES-1:0]   clrMask;
    logic [N_SOURCES-1:0]   candMask;
    logic                   scanning;
    logic                   curActiveFall;
    logic                   abortNow;
    logic [INC_WIDTH-1:0]   overrunInc;
    logic [16:0]            overrunSum;
    logic                   pickValid;
    logic [SRC_WIDTH-1:0]   pickSrc;
    int unsigned            cand;
    logic [DATA_WIDTH-1:0]  curData;
    logic                   curPresent;
    logic                   lastIndex;
    logic                   latDone;

    // Trigger/abort edge detection, round-robin pick and read-data mux
    always_comb begin
        validRise     = readoutValid & ~validQ;
        activeFall    = activeQ & ~readoutActive;
        setMask       = validRise & readoutActive;
        scanning      = (state == ST_READ) || (state == ST_EMIT);
        curActiveFall = 1'b0;
        curData       = '0;
        curPresent    = 1'b0;
        overrunInc    = '0;
        pickValid     = 1'b0;
        pickSrc       = '0;
        cand          = 0;
        candMask      = '0;

        for (int i = 0; i < N_SOURCES; i++) begin
            if (readoutSel == SRC_WIDTH'(i)) begin
                curData       = readoutData[i*DATA_WIDTH +: DATA_WIDTH];
                curPresent    = readoutPresent[i];
                curActiveFall = scanning && activeFall[i];
            end
            // A trigger on an already-pending or currently-scanned source is merged
            if (setMask[i] && (pending[i] || (scanning && readoutSel == SRC_WIDTH'(i))))
                overrunInc = overrunInc + INC_WIDTH'(1);
        end
        if (curActiveFall)
            overrunInc = overrunInc + INC_WIDTH'(1);

        for (int k = 0; k < N_SOURCES; k++) begin
            cand     = (int'(rrPtr) + k) % N_SOURCES;
            candMask = N_SOURCES'(1) << cand;
            if (!pickValid && ((pending & candMask) != '0)) begin
                pickValid = 1'b1;
                pickSrc   = SRC_WIDTH'(cand);
            end
        end

        clrMask    = (state == ST_IDLE && pickValid) ? (N_SOURCES'(1) << pickSrc) : '0;
        abortNow   = abortPending || curActiveFall;
        lastIndex  = (readoutAddress == LAST_INDEX);
        latDone    = (latCnt == LAT_WIDTH'(RD_LATENCY - 1));
        overrunSum = 17'(overrunCount) + 17'(overrunInc);
    end

    // Scan FSM with registered stream, status and bookkeeping
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state          <= ST_IDLE;
            validQ         <= '0;
            activeQ        <= '0;
            pending        <= '0;
            rrPtr          <= '0;
            latCnt         <= '0;
            abortPending   <= 1'b0;
            readoutSel     <= '0;
            readoutAddress <= '0;
            streamSource   <= '0;
            streamIndex    <= '0;
            streamData     <= '0;
            streamValid    <= 1'b0;
            scanDone       <= 1'b0;
            busy           <= 1'b0;
            overrunCount   <= '0;
        end else begin
            validQ       <= readoutValid;
            activeQ      <= readoutActive;
            pending      <= (pending & ~clrMask) | setMask;
            overrunCount <= overrunSum[16] ? 16'hFFFF : overrunSum[15:0];
            scanDone     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pickValid) begin
                        readoutSel     <= pickSrc;
                        readoutAddress <= '0;
                        latCnt         <= '0;
                        abortPending   <= 1'b0;
                        busy           <= 1'b1;
                        state          <= ST_READ;
                    end
                end

                ST_READ: begin
                    if (abortNow) begin
                        scanDone <= 1'b1;
                        state    <= ST_DONE;
                    end else if (latDone) begin
`ifdef READOUT_STREAM_SKIP_ABSENT_EN
                        if (!curPresent) begin
                            latCnt <= '0;
                            if (lastIndex) begin
                                scanDone <= 1'b1;
                                state    <= ST_DONE;
                            end else begin
                                readoutAddress <= readoutAddress + 1'b1;
                            end
                        end else begin
                            streamSource <= readoutSel;
                            streamIndex  <= readoutAddress;
                            streamData   <= curData;
                            streamValid  <= 1'b1;
                            state        <= ST_EMIT;
                        end
`else
                        streamSource <= readoutSel;
                        streamIndex  <= readoutAddress;
                        streamData   <= curPresent ? curData : '0;
                        streamValid  <= 1'b1;
                        state        <= ST_EMIT;
`endif
                    end else begin
                        latCnt <= latCnt + 1'b1;
                    end
                end

                ST_EMIT: begin
                    // An abort is remembered; the beat on the bus still needs its handshake
                    if (curActiveFall)
                        abortPending <= 1'b1;
                    if (streamReady) begin
                        streamValid <= 1'b0;
                        latCnt      <= '0;
                        if (lastIndex || abortNow) begin
                            scanDone <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            readoutAddress <= readoutAddress + 1'b1;
                            state          <= ST_READ;
                        end
                    end
                end

                ST_DONE: begin
                    if (readoutSel == SRC_WIDTH'(N_SOURCES - 1))
                        rrPtr <= '0;
                    else
                        rrPtr <= readoutSel + 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_readout_stream_arbiter.sv
// Directed bench for readout_stream_arbiter: two sources, 32-entry scans, combinational
// readout memory model whose data encodes source and address.
module tb_readout_stream_arbiter;

    localparam int unsigned NS = 2;
    localparam int unsigned SW = 1;
    localparam int unsigned IW = 5;
    localparam int unsigned DW = 32;

    logic              sysClk = 1'b0;
    logic              sysReset = 1'b1;
    logic [NS-1:0]     readoutActive = '0;
    logic [NS-1:0]     readoutValid = '0;
    logic [SW-1:0]     readoutSel;
    logic [IW-1:0]     readoutAddress;
    logic [NS*DW-1:0]  readoutData;
    logic [NS-1:0]     readoutPresent;
    logic [SW-1:0]     streamSource;
    logic [IW-1:0]     streamIndex;
    logic [DW-1:0]     streamData;
    logic              streamValid;
    logic              streamReady = 1'b1;
    logic              scanDone;
    logic              busy;
    logic [15:0]       overrunCount;

    logic [31:0]       presentMask [NS];
    int                readyMode = 0;
    int                rdyCnt = 0;
    int                cyc = 0;
    int                doneCnt = 0;
    int                doneCyc = 0;
    int                checkCount = 0;
    int                passCount = 0;
    logic [SW-1:0]     bSrc [$];
    logic [IW-1:0]     bIdx [$];
    logic [DW-1:0]     bData [$];
    int                bCyc [$];

    always #5 sysClk = ~sysClk;

    readout_stream_arbiter #(
        .N_SOURCES(NS), .SRC_WIDTH(SW), .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .RD_LATENCY(1)
    ) dut (
        .sysClk(sysClk), .sysReset(sysReset),
        .readoutActive(readoutActive), .readoutValid(readoutValid),
        .readoutSel(readoutSel), .readoutAddress(readoutAddress),
        .readoutData(readoutData), .readoutPresent(readoutPresent),
        .streamSource(streamSource), .streamIndex(streamIndex), .streamData(streamData),
        .streamValid(streamValid), .streamReady(streamReady),
        .scanDone(scanDone), .busy(busy), .overrunCount(overrunCount)
    );

    // Memory model: entry = D000_0000 | src<<8 | addr
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            readoutData[s*DW +: DW] = 32'hD000_0000 | (32'(s) << 8) | 32'(readoutAddress);
            readoutPresent[s]       = presentMask[s][readoutAddress];
        end
    end

    // Sink ready pattern, updated just after each active edge
    always @(posedge sysClk) begin
        #1;
        rdyCnt = rdyCnt + 1;
        case (readyMode)
            0:       streamReady = 1'b1;
            1:       streamReady = ((rdyCnt % 3) == 0);
            2:       streamReady = !(streamValid && streamIndex == 5'd10);
            default: streamReady = 1'b0;
        endcase
    end

    // Beat and scanDone recorder
    always @(negedge sysClk) begin
        cyc = cyc + 1;
        if (!sysReset) begin
            if (streamValid && streamReady) begin
                bSrc.push_back(streamSource);
                bIdx.push_back(streamIndex);
                bData.push_back(streamData);
                bCyc.push_back(cyc);
            end
            if (scanDone) begin
                doneCnt = doneCnt + 1;
                doneCyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge sysClk);
        #1;
    endtask

    task automatic clearBeats();
        bSrc.delete(); bIdx.delete(); bData.delete(); bCyc.delete();
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        readoutValid = readoutValid | m;
        tick();
        readoutValid = readoutValid & ~m;
        tick();
    endtask

    task automatic waitDone(input int target, input int maxCycles, output bit ok);
        int n;
        n = 0;
        while (doneCnt < target && n < maxCycles) begin
            tick();
            n++;
        end
        ok = (doneCnt >= target);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checkCount++;
        if ({streamValid, busy, scanDone} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {streamValid, busy, scanDone});
        else passCount++;
        checkCount++;
        if (overrunCount !== 16'd0) $display("FAIL reset_overrun: got %0d expected 0", overrunCount);
        else passCount++;
        checkCount++;
        if ({readoutSel, readoutAddress, streamSource, streamIndex, streamData} !== '0)
            $display("FAIL reset_outputs: got %h expected 0", {readoutSel, readoutAddress, streamSource, streamIndex, streamData});
        else passCount++;
        sysReset = 1'b0;
        readoutActive = 2'b11;
        tick();
    endtask

    task automatic test_single_scan();
        bit ok;
        int target;
        int last;
        clearBeats();
        readyMode = 0;
        target = doneCnt + 1;
        pulse(2'b01);
        waitDone(target, 200, ok);
        checkCount++;
        if (!ok) $display("FAIL single_done_timeout: got %0d scans expected %0d", doneCnt, target);
        else passCount++;
        repeat (2) tick();
        checkCount++;
        if (bIdx.size() != 32) $display("FAIL single_beats: got %0d expected 32", bIdx.size());
        else passCount++;
        for (int k = 0; k < bIdx.size() && k < 32; k++) begin
            checkCount++;
            if ({bSrc[k], bIdx[k], bData[k]} !== {1'b0, 5'(k), 32'hD000_0000 | 32'(k)})
                $display("FAIL single_beat%0d: got %h expected %h", k, {bSrc[k], bIdx[k], bData[k]}, {1'b0, 5'(k), 32'hD000_0000 | 32'(k)});
            else passCount++;
            if (k > 0) begin
                checkCount++;
                if (bCyc[k] - bCyc[k-1] != 2) $display("FAIL single_rate%0d: got %0d cycles expected 2", k, bCyc[k] - bCyc[k-1]);
                else passCount++;
            end
        end
        checkCount++;
        if (doneCnt != target) $display("FAIL single_done_width: got %0d pulses expected %0d", doneCnt, target);
        else passCount++;
        if (bCyc.size() > 0) begin
            last = bCyc[bCyc.size()-1];
            checkCount++;
            if (doneCyc != last + 1) $display("FAIL single_done_time: got cycle %0d expected %0d", doneCyc, last + 1);
            else passCount++;
        end
        checkCount++;
        if (busy !== 1'b0) $display("FAIL single_busy: got %b expected 0", busy);
        else passCount++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int target;
        logic holdValid;
        logic [SW+IW+DW-1:0] held;
        clearBeats();
        readyMode = 1;
        target = doneCnt + 1;
        holdValid = 1'b0;
        held = '0;
        pulse(2'b10);
        for (int i = 0; i < 600 && doneCnt < target; i++) begin
            if (holdValid) begin
                checkCount++;
                if (!streamValid || {streamSource, streamIndex, streamData} !== held)
                    $display("FAIL bp_stable: got v=%b %h expected v=1 %h", streamValid, {streamSource, streamIndex, streamData}, held);
                else passCount++;
            end
            holdValid = streamValid && !streamReady;
            held = {streamSource, streamIndex, streamData};
            tick();
        end
        ok = (doneCnt >= target);
        checkCount++;
        if (!ok) $display("FAIL bp_done_timeout: got %0d scans expected %0d", doneCnt, target);
        else passCount++;
        tick();
        checkCount++;
        if (bIdx.size() != 32) $display("FAIL bp_beats: got %0d expected 32", bIdx.size());
        else passCount++;
        for (int k = 0; k < bIdx.size() && k < 32; k++) begin
            checkCount++;
            if ({bSrc[k], bIdx[k], bData[k]} !== {1'b1, 5'(k), 32'hD000_0100 | 32'(k)})
                $display("FAIL bp_beat%0d: got %h expected %h", k, {bSrc[k], bIdx[k], bData[k]}, {1'b1, 5'(k), 32'hD000_0100 | 32'(k)});
            else passCount++;
        end
        readyMode = 0;
        tick();
    endtask

    task automatic test_same_cycle();
        bit ok;
        int target;
        clearBeats();
        readyMode = 0;
        target = doneCnt + 2;
        pulse(2'b11);
        waitDone(target, 400, ok);
        checkCount++;
        if (!ok) $display("FAIL dual_done_timeout: got %0d scans expected %0d", doneCnt, target);
        else passCount++;
        repeat (2) tick();
        checkCount++;
        if (bIdx.size() != 64) $display("FAIL dual_beats: got %0d expected 64", bIdx.size());
        else passCount++;
        for (int k = 0; k < bIdx.size() && k < 64; k++) begin
            checkCount++;
            if ({bSrc[k], bIdx[k], bData[k]} !== {1'(k / 32), 5'(k % 32), 32'hD000_0000 | (32'(k / 32) << 8) | 32'(k % 32)})
                $display("FAIL dual_beat%0d: got %h expected %h", k, {bSrc[k], bIdx[k], bData[k]},
                         {1'(k / 32), 5'(k % 32), 32'hD000_0000 | (32'(k / 32) << 8) | 32'(k % 32)});
            else passCount++;
        end
        checkCount++;
        if (dut.rrPtr !== 1'b0) $display("FAIL dual_rrptr: got %0d expected 0", dut.rrPtr);
        else passCount++;
    endtask

    task automatic test_absent();
        bit ok;
        int target;
        logic [DW-1:0] expData;
        clearBeats();
        readyMode = 0;
        presentMask[0] = 32'h0002_0008;
        target = doneCnt + 1;
        pulse(2'b01);
        waitDone(target, 200, ok);
        checkCount++;
        if (!ok) $display("FAIL absent_done_timeout: got %0d scans expected %0d", doneCnt, target);
        else passCount++;
        repeat (2) tick();
`ifdef READOUT_STREAM_SKIP_ABSENT_EN
        checkCount++;
        if (bIdx.size() != 2) $display("FAIL absent_beats: got %0d expected 2", bIdx.size());
        else passCount++;
        if (bIdx.size() >= 2) begin
            checkCount++;
            if ({bIdx[0], bData[0], bIdx[1], bData[1]} !== {5'd3, 32'hD000_0003, 5'd17, 32'hD000_0011})
                $display("FAIL absent_fields: got %h expected %h", {bIdx[0], bData[0], bIdx[1], bData[1]}, {5'd3, 32'hD000_0003, 5'd17, 32'hD000_0011});
            else passCount++;
        end
`else
        checkCount++;
        if (bIdx.size() != 32) $display("FAIL absent_beats: got %0d expected 32", bIdx.size());
        else passCount++;
        for (int k = 0; k < bIdx.size() && k < 32; k++) begin
            expData = (k == 3 || k == 17) ? (32'hD000_0000 | 32'(k)) : 32'h0;
            checkCount++;
            if ({bIdx[k], bData[k]} !== {5'(k), expData})
                $display("FAIL absent_beat%0d: got %h expected %h", k, {bIdx[k], bData[k]}, {5'(k), expData});
            else passCount++;
        end
`endif
        presentMask[0] = '1;
    endtask

    task automatic test_overrun();
        bit ok;
        int target;
        int n;
        clearBeats();
        readyMode = 0;
        target = doneCnt + 2;
        pulse(2'b01);
        n = 0;
        while (bIdx.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        checkCount++;
        if (bIdx.size() == 0) $display("FAIL overrun_start_timeout: got 0 beats expected >0");
        else passCount++;
        pulse(2'b01);
        checkCount++;
        if (overrunCount !== 16'd1) $display("FAIL overrun_count: got %0d expected 1", overrunCount);
        else passCount++;
        waitDone(target, 400, ok);
        checkCount++;
        if (!ok) $display("FAIL overrun_done_timeout: got %0d scans expected %0d", doneCnt, target);
        else passCount++;
        repeat (2) tick();
        checkCount++;
        if (bIdx.size() != 64) $display("FAIL overrun_beats: got %0d expected 64", bIdx.size());
        else passCount++;
        for (int k = 0; k < bIdx.size() && k < 64; k++) begin
            checkCount++;
            if ({bSrc[k], bIdx[k]} !== {1'b0, 5'(k % 32)})
                $display("FAIL overrun_beat%0d: got %h expected %h", k, {bSrc[k], bIdx[k]}, {1'b0, 5'(k % 32)});
            else passCount++;
        end
    endtask

    task automatic test_abort();
        bit ok;
        int target;
        int n;
        clearBeats();
        readyMode = 2;
        target = doneCnt + 1;
        pulse(2'b10);
        n = 0;
        while (!(streamValid && streamIndex == 5'd10) && n < 100) begin
            tick();
            n++;
        end
        checkCount++;
        if (!(streamValid && streamIndex == 5'd10)) $display("FAIL abort_reach_timeout: got idx %0d expected 10", streamIndex);
        else passCount++;
        readoutActive = 2'b01;
        repeat (3) tick();
        checkCount++;
        if ({streamValid, streamSource, streamIndex} !== {1'b1, 1'b1, 5'd10})
            $display("FAIL abort_hold: got %b expected %b", {streamValid, streamSource, streamIndex}, {1'b1, 1'b1, 5'd10});
        else passCount++;
        checkCount++;
        if (doneCnt != target - 1) $display("FAIL abort_early_done: got %0d scans expected %0d", doneCnt, target - 1);
        else passCount++;
        checkCount++;
        if (overrunCount !== 16'd2) $display("FAIL abort_overrun: got %0d expected 2", overrunCount);
        else passCount++;
        readyMode = 0;
        waitDone(target, 20, ok);
        checkCount++;
        if (!ok) $display("FAIL abort_done_timeout: got %0d scans expected %0d", doneCnt, target);
        else passCount++;
        repeat (2) tick();
        checkCount++;
        if (bIdx.size() != 11) $display("FAIL abort_beats: got %0d expected 11", bIdx.size());
        else passCount++;
        if (bIdx.size() > 0) begin
            checkCount++;
            if (bIdx[bIdx.size()-1] !== 5'd10) $display("FAIL abort_last_idx: got %0d expected 10", bIdx[bIdx.size()-1]);
            else passCount++;
        end
        checkCount++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy);
        else passCount++;
        readoutActive = 2'b11;
        tick();
    endtask

    task automatic test_reset_midscan();
        int n;
        readyMode = 0;
        pulse(2'b01);
        n = 0;
        while (!streamValid && n < 20) begin
            tick();
            n++;
        end
        checkCount++;
        if (!streamValid) $display("FAIL rst_mid_start_timeout: got valid 0 expected 1");
        else passCount++;
        sysReset = 1'b1;
        #1;
        checkCount++;
        if ({streamValid, busy, scanDone} !== 3'b000) $display("FAIL rst_mid_flags: got %b expected 000", {streamValid, busy, scanDone});
        else passCount++;
        checkCount++;
        if (overrunCount !== 16'd0) $display("FAIL rst_mid_overrun: got %0d expected 0", overrunCount);
        else passCount++;
        tick();
        sysReset = 1'b0;
        repeat (3) tick();
        checkCount++;
        if ({busy, streamValid} !== 2'b00) $display("FAIL rst_mid_idle: got %b expected 00", {busy, streamValid});
        else passCount++;
    endtask

    initial begin
        presentMask[0] = '1;
        presentMask[1] = '1;
        test_reset();
        test_single_scan();
        test_backpressure();
        test_same_cycle();
        test_absent();
        test_overrun();
        test_abort();
        test_reset_midscan();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
